// File: rtl/jk_vector_counter.sv
// WIDTH-bit register of JK cells with clock enable, parallel load and
// modulo up/down counting. Flags: terminal count (tc) and a one-cycle wrap pulse.
module jk_vector_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc,
  output logic             wrap
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK:   q_next = (j & ~q) | (~k & q);
        MODE_LOAD: q_next = d;
        MODE_UP: begin
          // Out-of-range values (after LOAD/JK) restart at zero as a wrap.
          if (q < MAX_V) begin
            q_next = q + ONE_V;
          end else begin
            q_next    = ZERO_V;
            wrap_next = 1'b1;
          end
        end
        default: begin
          if (q == ZERO_V) begin
            q_next    = MAX_V;
            wrap_next = 1'b1;
          end else if (q > MAX_V) begin
            q_next = MAX_V;
          end else begin
            q_next = q - ONE_V;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RST_V;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

  assign q_n = ~q;
  assign tc  = ((mode == MODE_UP) && (q == MAX_V)) ||
               ((mode == MODE_DOWN) && (q == ZERO_V));

endmodule

// File: doc/jk_vector_counter.md
Name: jk_vector_counter

Overview:
- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit register of JK cells.
- Adds clock enable, parallel load, and modulo up/down count modes, with terminal-count and wrap flags.
- Used as a general state/counter element in later labs, such as dividers, sequencers and BCD counters.

Parameters:
WIDTH, 8, register width in bits (>=1)
MAX_COUNT, 2**WIDTH-1, count modulus minus one; legal range 1..2**WIDTH-1
RESET_VAL, 0, value of q after reset; must fit in WIDTH bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  clock enable; 0 = hold all state
mode  input  2  00 JK, 01 LOAD, 10 UP, 11 DOWN
j  input  WIDTH  per-bit J inputs (JK mode only)
k  input  WIDTH  per-bit K inputs (JK mode only)
d  input  WIDTH  parallel load data (LOAD mode only)
q  output  WIDTH  registered state
q_n  output  WIDTH  bitwise complement of q (combinational)
tc  output  1  terminal count (combinational)
wrap  output  1  registered one-cycle pulse on count wrap

Behaviour:
- Reset: rst_n low forces q=RESET_VAL and wrap=0 immediately, independent of clk. Release is sampled at the next rising edge; no update occurs on the edge where rst_n is low.
- All updates happen on the rising clk edge, with 1-cycle latency from inputs to q/wrap.
- en=0: q holds and wrap=0 on that edge, whatever the mode.
- JK mode (en=1, mode=00), per bit i:
  - j=0,k=0: hold.
  - j=0,k=1: clear to 0.
  - j=1,k=0: set to 1.
  - j=1,k=1: toggle.
  - Bits are independent. wrap=0.
- LOAD mode (mode=01): q<=d unmodified, even if d>MAX_COUNT. wrap=0.
- UP mode (mode=10):
  - q<MAX_COUNT: q<=q+1, wrap<=0.
  - q==MAX_COUNT: q<=0, wrap<=1.
  - q>MAX_COUNT (out of range after LOAD/JK): q<=0, wrap<=1.
- DOWN mode (mode=11):
  - 0<q<=MAX_COUNT: q<=q-1, wrap<=0.
  - q==0: q<=MAX_COUNT, wrap<=1.
  - q>MAX_COUNT: q<=MAX_COUNT, wrap<=0.
- Arithmetic is WIDTH bits with no carry out. MAX_COUNT=2**WIDTH-1 gives natural binary rollover.
- tc=1 when (mode==UP and q==MAX_COUNT) or (mode==DOWN and q==0); else 0. tc ignores en, and tc is 0 in JK and LOAD modes.
- wrap is high for exactly one cycle per wrap event. In continuous counting it pulses every MAX_COUNT+1 enabled cycles.
- Mode changes take effect on the next edge with no pipeline state. UP→DOWN at q==MAX_COUNT counts to MAX_COUNT-1, with no wrap.
- Reset asserted mid-count clears q to RESET_VAL and aborts any pending wrap pulse. After release, counting resumes from RESET_VAL.
- q_n is always ~q, including during reset.

Test Plan:
1. WIDTH=4, MAX_COUNT=9, RESET_VAL=0: rst_n=0 pulse mid-cycle -> q=0, q_n=4'hF, wrap=0 immediately, before the next clk edge.
2. JK mode, q=4'b0000. Edge 1: j=4'b1010, k=4'b0000 -> q=4'b1010. Edge 2: j=4'b1111, k=4'b1111 -> q=4'b0101. Edge 3: j=0, k=4'b0100 -> q=4'b0001.
3. UP, en=1 from q=0 for 12 edges -> q=1..9,0,1,2. tc=1 only while q==9. wrap=1 for exactly the cycle after q goes 9→0.
4. DOWN from q=2 for 4 edges -> q=1,0,9,8. tc=1 while q==0. wrap pulses once, after 0→9.
5. LOAD d=4'd13, then UP -> q=13, then 0 with wrap=1. LOAD 13, then DOWN -> q=9 with wrap=0.
6. UP with en toggling 1,0,0,1 from q=8 -> q=9,9,9,0. wrap=0 on the disabled edges and 1 after the final edge. Assert rst_n during count at q=5 -> q=0 at once, wrap=0.
